// File: rtl/fios_res_collect.sv
// fios_res_collect: collects WORD_COUNT 17-bit result words from successive
// unnormalised 34-bit DSP P outputs. Each P value carries the low word plus
// a pending carry; the carry from each word is added into the next P.
// The `ifdef FIOS_COLLECT_ERR_EN macro adds the sticky protocol-error output err_o.
// Reset release is expected to be synchronised to clock_i by the parent.
module fios_res_collect #(
  parameter int WORD_COUNT = 8,
  parameter int WORD_W     = 17
) (
  input  logic                         clock_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         p_valid_i,
  input  logic [2*WORD_W-1:0]          P_i,
  output logic [WORD_COUNT*WORD_W-1:0] res_o,
  output logic [WORD_W:0]              carry_o,
  output logic                         res_valid_o,
  output logic                         busy_o
`ifdef FIOS_COLLECT_ERR_EN
  ,
  output logic                         err_o
`endif
);

  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int SUM_W = 2*WORD_W + 1;
  localparam int CRY_W = WORD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CRY_W-1:0]               carry_q, carry_d;
  logic [WORD_COUNT*WORD_W-1:0]   res_q;
  logic [SUM_W-1:0]               sum;
  logic                           accept;

  // The carry can never exceed 18 bits, so a 35-bit sum is wide enough.
  assign sum = {1'b0, P_i} + {{(SUM_W-CRY_W){1'b0}}, carry_q};

  // Next-state logic: start_i restarts from any state and wins over p_valid_i.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    accept  = 1'b0;
    if (start_i) begin
      state_d = ST_COLLECT;
      idx_d   = '0;
      carry_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_COLLECT: begin
          if (p_valid_i) begin
            accept  = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
            carry_d = sum[SUM_W-1:WORD_W];
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and carry registers.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  // Result words are written in place; a restart leaves stale words until overwritten.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < WORD_COUNT; k++) begin
        if (idx_q == IDX_W'(k)) begin
          res_q[k*WORD_W +: WORD_W] <= sum[WORD_W-1:0];
        end
      end
    end
  end

`ifdef FIOS_COLLECT_ERR_EN
  logic err_q, err_d;

  // Sticky error: a valid word offered outside COLLECT without a start.
  always_comb begin
    err_d = err_q;
    if (start_i) begin
      err_d = 1'b0;
    end else if (p_valid_i && (state_q != ST_COLLECT)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign res_o       = res_q;
  assign carry_o     = carry_q;
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_COLLECT);

endmodule
